// File: rtl/seg_hex_display_if.sv
// Display bus: digit value writes, per-digit display controls and the segment outputs.
interface seg_hex_display_if #(
  parameter int unsigned DIGITS = 8
);
  logic                    wr_en;
  logic [DIGITS-1:0]       wr_mask;
  logic [4*DIGITS-1:0]     wr_data;
  logic [DIGITS-1:0]       digit_en;
  logic [DIGITS-1:0]       dp_mask;
  logic [DIGITS-1:0]       blink_mask;
  logic                    lz_en;
  logic [8*DIGITS-1:0]     seg;
  logic                    blink_phase;

  // Core / bench side: drives writes and controls, observes segments.
  modport master (
    output wr_en, wr_mask, wr_data, digit_en, dp_mask, blink_mask, lz_en,
    input  seg, blink_phase
  );

  // Display controller side.
  modport slave (
    input  wr_en, wr_mask, wr_data, digit_en, dp_mask, blink_mask, lz_en,
    output seg, blink_phase
  );
endinterface

// File: rtl/seg_hex_display.sv
// Registered multi-digit hex to seven-segment controller with per-digit enable,
// decimal point, leading-zero suppression and a free-running blink generator.
module seg_hex_display #(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  seg_hex_display_if.slave    bus
);

  localparam int unsigned    CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [DIGITS-1:0][3:0] val_q, val_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   phase_q, phase_d;
  logic [DIGITS-1:0][7:0] seg_q, seg_d;
  logic [DIGITS-1:0]      supp_c;

  // Active-low glyph for a hex nibble, dp bit left dark.
  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 8'h03;  4'h1: glyph = 8'h9F;
      4'h2: glyph = 8'h25;  4'h3: glyph = 8'h0D;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h49;
      4'h6: glyph = 8'h41;  4'h7: glyph = 8'h1F;
      4'h8: glyph = 8'h01;  4'h9: glyph = 8'h09;
      4'hA: glyph = 8'h11;  4'hB: glyph = 8'hC1;
      4'hC: glyph = 8'h63;  4'hD: glyph = 8'h85;
      4'hE: glyph = 8'h61;  default: glyph = 8'h71;
    endcase
  endfunction

  // Masked per-digit value load.
  always_comb begin
    val_d = val_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bus.wr_en && bus.wr_mask[i]) begin
        val_d[i] = bus.wr_data[4*i +: 4];
      end
    end
  end

  // Blink counter wraps at BLINK_DIV-1 and flips the phase on the wrap.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Leading-zero run scanned from the MSB; disabled digits are transparent.
  always_comb begin : lz_scan
    logic run;
    run    = 1'b1;
    supp_c = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      if (bus.digit_en[i]) begin
        if (val_q[i] == 4'h0) begin
          supp_c[i] = bus.lz_en && run && (i != 0);
        end else begin
          run = 1'b0;
        end
      end
    end
  end

  // Per-digit output priority: disabled, blink-off, suppressed, glyph.
  always_comb begin
    seg_d = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!bus.digit_en[i]) begin
        seg_d[i] = 8'hFF;
      end else if (phase_q && bus.blink_mask[i]) begin
        seg_d[i] = 8'hFF;
      end else begin
        seg_d[i]    = supp_c[i] ? 8'hFF : glyph(val_q[i]);
        seg_d[i][0] = ~bus.dp_mask[i];
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      val_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      seg_q   <= '1;
    end else begin
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.blink_phase = phase_q;

endmodule
